// File: rtl/markup_scheduler_if.sv
// Signal bundle between the markup scheduler and its neighbours: character source,
// element_parser, layout event sink and the sticky error status.
interface markup_scheduler_if #(
    parameter int CHAR_BITES           = 8,
    parameter int ELE_TAG_BITES        = 3,
    parameter int ATTRIBUTE_TYPE_BITES = 3,
    parameter int ATTRIBUTE_VAL_BITES  = 16,
    parameter int DEPTH_W              = 4
);
    logic [CHAR_BITES-1:0]           in_char;
    logic                            in_valid;
    logic                            in_ready;

    logic [CHAR_BITES-1:0]           p_char;
    logic                            p_enable;
    logic                            p_finished;
    logic [ELE_TAG_BITES-1:0]        p_tag;
    logic                            p_type;
    logic                            p_has_attr;
    logic [ATTRIBUTE_TYPE_BITES-1:0] p_attr_type;
    logic [ATTRIBUTE_VAL_BITES-1:0]  p_attr_value;

    logic                            ev_valid;
    logic                            ev_ready;
    logic [1:0]                      ev_kind;
    logic [ELE_TAG_BITES-1:0]        ev_tag;
    logic [DEPTH_W-1:0]              ev_depth;
    logic [ATTRIBUTE_TYPE_BITES-1:0] ev_attr_type;
    logic [ATTRIBUTE_VAL_BITES-1:0]  ev_data;

    logic                            error;
    logic [1:0]                      error_code;

    modport master (
        input  in_char, in_valid,
        output in_ready,
        output p_char, p_enable,
        input  p_finished, p_tag, p_type, p_has_attr, p_attr_type, p_attr_value,
        output ev_valid, ev_kind, ev_tag, ev_depth, ev_attr_type, ev_data,
        input  ev_ready,
        output error, error_code
    );

    modport slave (
        output in_char, in_valid,
        input  in_ready,
        input  p_char, p_enable,
        output p_finished, p_tag, p_type, p_has_attr, p_attr_type, p_attr_value,
        input  ev_valid, ev_kind, ev_tag, ev_depth, ev_attr_type, ev_data,
        output ev_ready,
        input  error, error_code
    );
endinterface

// File: rtl/markup_scheduler.sv
// Markup front-end sequencer: splits text from tags, feeds element_parser, tracks
// nesting on a tag stack and serialises open/close/attribute/text events.
module markup_scheduler #(
    parameter int STACK_DEPTH          = 8,
    parameter int DEPTH_W              = 4,
    parameter int CHAR_BITES           = 8,
    parameter int ELE_TAG_BITES        = 3,
    parameter int ATTRIBUTE_TYPE_BITES = 3,
    parameter int ATTRIBUTE_VAL_BITES  = 16
) (
    input logic                clock,
    input logic                reset_n,
    markup_scheduler_if.master bus
);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    localparam logic [CHAR_BITES-1:0] CH_LT  = CHAR_BITES'(8'h3C);
    localparam logic [CHAR_BITES-1:0] CH_GT  = CHAR_BITES'(8'h3E);
    localparam logic [CHAR_BITES-1:0] CH_SP  = CHAR_BITES'(8'h20);
    localparam logic [CHAR_BITES-1:0] CH_TAB = CHAR_BITES'(8'h09);
    localparam logic [CHAR_BITES-1:0] CH_LF  = CHAR_BITES'(8'h0A);
    localparam logic [CHAR_BITES-1:0] CH_CR  = CHAR_BITES'(8'h0D);

    localparam logic [1:0] EV_OPEN  = 2'd0;
    localparam logic [1:0] EV_CLOSE = 2'd1;
    localparam logic [1:0] EV_ATTR  = 2'd2;
    localparam logic [1:0] EV_TEXT  = 2'd3;

    localparam logic [1:0] ERR_OVER     = 2'd1;
    localparam logic [1:0] ERR_UNDER    = 2'd2;
    localparam logic [1:0] ERR_MISMATCH = 2'd3;

    typedef enum logic [2:0] {SCAN, FEED, WAIT_FIN, CLEAR, HALT} state_t;

    state_t state, state_nxt;

    logic                            armed;
    logic [CHAR_BITES-1:0]           p_char_q;
    logic                            p_enable_q, p_enable_nxt;

    logic                            ev_valid_q;
    logic [1:0]                      ev_kind_q;
    logic [ELE_TAG_BITES-1:0]        ev_tag_q;
    logic [DEPTH_W-1:0]              ev_depth_q;
    logic [ATTRIBUTE_TYPE_BITES-1:0] ev_attr_type_q;
    logic [ATTRIBUTE_VAL_BITES-1:0]  ev_data_q;

    logic [ELE_TAG_BITES-1:0]        stack [STACK_DEPTH];
    logic [DEPTH_W-1:0]              depth, depth_nxt, depth_m1;
    logic                            attr_seen;
    logic                            error_q, error_nxt;
    logic [1:0]                      error_code_q, error_code_nxt;

    logic                            slot_free, in_ready, accept, is_space;
    logic                            attr_fire, fin_fire, feed, push;
    logic [ELE_TAG_BITES-1:0]        top_tag;

    logic                            load;
    logic [1:0]                      kind_nxt;
    logic [ELE_TAG_BITES-1:0]        tag_nxt;
    logic [DEPTH_W-1:0]              ev_depth_nxt;
    logic [ATTRIBUTE_TYPE_BITES-1:0] attr_type_nxt;
    logic [ATTRIBUTE_VAL_BITES-1:0]  data_nxt;

    assign depth_m1  = depth - DEPTH_W'(1);
    assign top_tag   = (depth == '0) ? '0 : stack[depth_m1[IDX_W-1:0]];
    assign slot_free = !ev_valid_q || bus.ev_ready;

    // armed keeps in_ready low while reset is asserted and for the first cycle after it
    assign in_ready  = armed && ((state == SCAN) || (state == FEED)) && slot_free;
    assign accept    = bus.in_valid && in_ready;
    assign is_space  = (bus.in_char == CH_SP) || (bus.in_char == CH_TAB) ||
                       (bus.in_char == CH_LF) || (bus.in_char == CH_CR);

    // Attribute capture wins the slot; finish handling waits for the next loadable cycle
    assign attr_fire = ((state == FEED) || (state == WAIT_FIN)) && bus.p_has_attr &&
                       !attr_seen && slot_free;
    assign fin_fire  = (state == WAIT_FIN) && bus.p_finished && slot_free && !attr_fire;

    always_comb begin
        state_nxt      = state;
        p_enable_nxt   = p_enable_q;
        feed           = 1'b0;
        push           = 1'b0;
        depth_nxt      = depth;
        error_nxt      = error_q;
        error_code_nxt = error_code_q;
        load           = 1'b0;
        kind_nxt       = EV_TEXT;
        tag_nxt        = top_tag;
        ev_depth_nxt   = depth;
        attr_type_nxt  = '0;
        data_nxt       = ATTRIBUTE_VAL_BITES'(bus.in_char);

        case (state)
            SCAN: begin
                if (accept) begin
                    if (bus.in_char == CH_LT) state_nxt = FEED;
                    else if (!is_space)       load      = 1'b1;
                end
            end
            FEED: begin
                if (accept) begin
                    feed         = 1'b1;
                    p_enable_nxt = 1'b1;
                    if (bus.in_char == CH_GT) state_nxt = WAIT_FIN;
                end
            end
            WAIT_FIN: begin
                if (fin_fire) begin
                    state_nxt    = CLEAR;
                    p_enable_nxt = 1'b0;
                    tag_nxt      = bus.p_tag;
                    data_nxt     = '0;
                    if (!bus.p_type) begin
                        if (depth == DEPTH_MAX) begin
                            error_nxt      = 1'b1;
                            error_code_nxt = ERR_OVER;
                            state_nxt      = HALT;
                        end else begin
                            load      = 1'b1;
                            kind_nxt  = EV_OPEN;
                            push      = 1'b1;
                            depth_nxt = depth + DEPTH_W'(1);
                        end
                    end else if (depth == '0) begin
                        error_nxt      = 1'b1;
                        error_code_nxt = ERR_UNDER;
                        state_nxt      = HALT;
                    end else if (top_tag != bus.p_tag) begin
                        error_nxt      = 1'b1;
                        error_code_nxt = ERR_MISMATCH;
                        state_nxt      = HALT;
                    end else begin
                        load         = 1'b1;
                        kind_nxt     = EV_CLOSE;
                        depth_nxt    = depth_m1;
                        ev_depth_nxt = depth_m1;
                    end
                end
            end
            CLEAR:   state_nxt = SCAN;
            HALT:    state_nxt = HALT;
            default: state_nxt = SCAN;
        endcase

        if (attr_fire) begin
            load          = 1'b1;
            kind_nxt      = EV_ATTR;
            tag_nxt       = bus.p_tag;
            ev_depth_nxt  = depth;
            attr_type_nxt = bus.p_attr_type;
            data_nxt      = bus.p_attr_value;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= SCAN;
            armed          <= 1'b0;
            p_char_q       <= '0;
            p_enable_q     <= 1'b0;
            ev_valid_q     <= 1'b0;
            ev_kind_q      <= '0;
            ev_tag_q       <= '0;
            ev_depth_q     <= '0;
            ev_attr_type_q <= '0;
            ev_data_q      <= '0;
            depth          <= '0;
            attr_seen      <= 1'b0;
            error_q        <= 1'b0;
            error_code_q   <= '0;
        end else begin
            state        <= state_nxt;
            armed        <= 1'b1;
            p_enable_q   <= p_enable_nxt;
            depth        <= depth_nxt;
            error_q      <= error_nxt;
            error_code_q <= error_code_nxt;
            if (feed) p_char_q <= bus.in_char;

            if (attr_fire)            attr_seen <= 1'b1;
            else if (!bus.p_has_attr) attr_seen <= 1'b0;

            if (load) begin
                ev_valid_q     <= 1'b1;
                ev_kind_q      <= kind_nxt;
                ev_tag_q       <= tag_nxt;
                ev_depth_q     <= ev_depth_nxt;
                ev_attr_type_q <= attr_type_nxt;
                ev_data_q      <= data_nxt;
            end else if (bus.ev_ready) begin
                ev_valid_q <= 1'b0;
            end
        end
    end

    // Entries above depth are don't-care, so the stack storage needs no reset
    always_ff @(posedge clock) begin
        if (push) stack[depth[IDX_W-1:0]] <= bus.p_tag;
    end

    assign bus.in_ready     = in_ready;
    assign bus.p_char       = p_char_q;
    assign bus.p_enable     = p_enable_q;
    assign bus.ev_valid     = ev_valid_q;
    assign bus.ev_kind      = ev_kind_q;
    assign bus.ev_tag       = ev_tag_q;
    assign bus.ev_depth     = ev_depth_q;
    assign bus.ev_attr_type = ev_attr_type_q;
    assign bus.ev_data      = ev_data_q;
    assign bus.error        = error_q;
    assign bus.error_code   = error_code_q;
endmodule

// File: tb/tb_markup_scheduler.sv
// Bench for markup_scheduler: behavioural element_parser, document-level event model,
// directed documents from the test plan plus randomly generated documents.
module tb_markup_scheduler;
    localparam int STACK_DEPTH = 8;
    localparam int DEPTH_W     = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    markup_scheduler_if #(.CHAR_BITES(8), .ELE_TAG_BITES(3), .ATTRIBUTE_TYPE_BITES(3),
                          .ATTRIBUTE_VAL_BITES(16), .DEPTH_W(DEPTH_W)) bus ();

    markup_scheduler #(.STACK_DEPTH(STACK_DEPTH), .DEPTH_W(DEPTH_W), .CHAR_BITES(8),
                       .ELE_TAG_BITES(3), .ATTRIBUTE_TYPE_BITES(3),
                       .ATTRIBUTE_VAL_BITES(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  tag;
        logic [3:0]  depth;
        logic [2:0]  atype;
        logic [15:0] data;
    } ev_t;

    ev_t exp_q[$];
    ev_t got_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  rdy_mode = 0;
    int  idle_max = 0;
    int  cyc      = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Tag text (between < and >) -> what element_parser reports for it
    function automatic void tag_info(input string s, output bit cl, output logic [2:0] tag,
                                     output bit ha, output logic [2:0] at, output logic [15:0] av);
        int i = 0;
        int st;
        string name;
        cl = 0; ha = 0; at = '0; av = '0;
        if (s.len() > 0 && s[0] == 8'h2F) begin cl = 1; i = 1; end
        st = i;
        while (i < s.len() && s[i] != 8'h20) i++;
        name = s.substr(st, i - 1);
        if (name == "d")      tag = 3'd0;
        else if (name == "p") tag = 3'd1;
        else if (name == "b") tag = 3'd2;
        else if (name == "a") tag = 3'd3;
        else                  tag = 3'd7;
        while (i < s.len() && s[i] == 8'h20) i++;
        if (i < s.len()) begin
            ha = 1;
            at = 3'((s.len() - i) % 8);
            for (int k = i; k < s.len(); k++) av += 16'(s[k]) * 16'(k - i + 1);
        end
    endfunction

    // Document-level reference: events and final error from the nesting rules
    function automatic void ref_model(input string doc, output bit e_err, output logic [1:0] e_code);
        int    stk[$];
        bit    in_tag = 0;
        string content = "";
        bit    cl, ha;
        logic [2:0]  tg, at;
        logic [15:0] av;
        ev_t   e;
        exp_q.delete();
        e_err = 0; e_code = 2'd0;
        for (int i = 0; i < doc.len() && !e_err; i++) begin
            byte c = doc[i];
            if (!in_tag) begin
                if (c == 8'h3C) begin in_tag = 1; content = ""; end
                else if (!(c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D)) begin
                    e.kind = 2'd3; e.tag = (stk.size() > 0) ? 3'(stk[$]) : 3'd0;
                    e.depth = 4'(stk.size()); e.atype = '0; e.data = 16'(c);
                    exp_q.push_back(e);
                end
            end else if (c != 8'h3E) begin
                content = $sformatf("%s%c", content, c);
            end else begin
                in_tag = 0;
                tag_info(content, cl, tg, ha, at, av);
                if (ha) begin
                    e.kind = 2'd2; e.tag = tg; e.depth = 4'(stk.size()); e.atype = at; e.data = av;
                    exp_q.push_back(e);
                end
                if (!cl) begin
                    if (stk.size() == STACK_DEPTH) begin e_err = 1; e_code = 2'd1; end
                    else begin
                        e.kind = 2'd0; e.tag = tg; e.depth = 4'(stk.size()); e.atype = '0; e.data = '0;
                        exp_q.push_back(e);
                        stk.push_back(int'(tg));
                    end
                end else if (stk.size() == 0) begin e_err = 1; e_code = 2'd2; end
                else if (stk[$] != int'(tg)) begin e_err = 1; e_code = 2'd3; end
                else begin
                    void'(stk.pop_back());
                    e.kind = 2'd1; e.tag = tg; e.depth = 4'(stk.size()); e.atype = '0; e.data = '0;
                    exp_q.push_back(e);
                end
            end
        end
    endfunction

    // Behavioural element_parser: samples p_char once per forwarded character
    initial begin
        string       pbuf = "", n_buf;
        logic        acc_d = 0, acc_now;
        logic        n_fin, n_type, n_ha;
        logic [2:0]  n_tag, n_at;
        logic [15:0] n_av;
        bit          cl, ha;
        logic [2:0]  tg, at;
        logic [15:0] av;
        bus.p_finished = 0; bus.p_tag = '0; bus.p_type = 0;
        bus.p_has_attr = 0; bus.p_attr_type = '0; bus.p_attr_value = '0;
        forever begin
            @(negedge clock);
            n_buf = pbuf; n_fin = bus.p_finished; n_type = bus.p_type; n_tag = bus.p_tag;
            n_ha = bus.p_has_attr; n_at = bus.p_attr_type; n_av = bus.p_attr_value;
            if (!reset_n || !bus.p_enable) begin
                n_buf = ""; n_fin = 0; n_type = 0; n_tag = '0; n_ha = 0; n_at = '0; n_av = '0;
            end else if (acc_d) begin
                if (bus.p_char == 8'h3E) begin
                    tag_info(pbuf, cl, tg, ha, at, av);
                    n_fin = 1; n_type = cl; n_tag = tg; n_ha = ha; n_at = at; n_av = av;
                end else begin
                    n_buf = $sformatf("%s%c", pbuf, bus.p_char);
                end
            end
            acc_now = bus.in_valid && bus.in_ready;
            @(posedge clock);
            #1;
            if (!reset_n) begin
                n_buf = ""; n_fin = 0; n_type = 0; n_tag = '0; n_ha = 0; n_at = '0; n_av = '0;
                acc_now = 0;
            end
            pbuf = n_buf; acc_d = acc_now;
            bus.p_finished = n_fin; bus.p_type = n_type; bus.p_tag = n_tag;
            bus.p_has_attr = n_ha; bus.p_attr_type = n_at; bus.p_attr_value = n_av;
        end
    end

    // Layout-side ready pattern: 0 always ready, 1 random, 2 repeating 1-0-0-1
    initial begin
        bus.ev_ready = 0;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            case (rdy_mode)
                0:       bus.ev_ready = 1'b1;
                1:       bus.ev_ready = 1'($urandom_range(0, 1));
                default: bus.ev_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            endcase
        end
    end

    // Event monitor: records transfers and checks the slot holds still while stalled
    initial begin
        bit  stalled = 0;
        ev_t held, cur;
        forever begin
            @(negedge clock);
            if (reset_n && bus.ev_valid) begin
                cur.kind = bus.ev_kind; cur.tag = bus.ev_tag; cur.depth = bus.ev_depth;
                cur.atype = bus.ev_attr_type; cur.data = bus.ev_data;
                if (stalled) begin
                    check_val("hold_kind", cur.kind, held.kind);
                    check_val("hold_tag", cur.tag, held.tag);
                    check_val("hold_depth", cur.depth, held.depth);
                    check_val("hold_data", cur.data, held.data);
                end
                if (bus.ev_ready) got_q.push_back(cur);
                stalled = !bus.ev_ready;
                held = cur;
            end else begin
                stalled = 0;
            end
        end
    end

    task automatic reset_dut();
        bus.in_valid = 0;
        reset_n = 0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1;
        @(posedge clock);
        #1;
    endtask

    task automatic send_doc(input string doc);
        for (int i = 0; i < doc.len(); i++) begin
            int waited = 0;
            bit done = 0;
            bus.in_valid = 0;
            repeat ($urandom_range(0, idle_max)) begin @(posedge clock); #1; end
            bus.in_char  = doc[i];
            bus.in_valid = 1;
            while (!done) begin
                @(negedge clock);
                if (bus.in_ready) done = 1;
                else if (bus.error) begin bus.in_valid = 0; return; end
                else if (++waited > 200) begin
                    check_val($sformatf("accept_ch%0d", i), 0, 1);
                    bus.in_valid = 0;
                    return;
                end
                @(posedge clock);
                #1;
            end
        end
        bus.in_valid = 0;
    endtask

    task automatic run_doc(input string doc, input int mode, input bit do_rst);
        bit         e_err;
        logic [1:0] e_code;
        int         n;
        if (do_rst) reset_dut();
        rdy_mode = mode;
        got_q.delete();
        ref_model(doc, e_err, e_code);
        send_doc(doc);
        repeat (40) begin @(posedge clock); #1; end
        @(negedge clock);
        check_val("ev_count", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check_val($sformatf("ev%0d_kind", k), got_q[k].kind, exp_q[k].kind);
            check_val($sformatf("ev%0d_tag", k), got_q[k].tag, exp_q[k].tag);
            check_val($sformatf("ev%0d_depth", k), got_q[k].depth, exp_q[k].depth);
            if (exp_q[k].kind == 2'd2)
                check_val($sformatf("ev%0d_atype", k), got_q[k].atype, exp_q[k].atype);
            if (exp_q[k].kind >= 2'd2)
                check_val($sformatf("ev%0d_data", k), got_q[k].data, exp_q[k].data);
        end
        check_val("error", bus.error, e_err);
        check_val("error_code", bus.error_code, e_code);
        if (e_err) check_val("halt_in_ready", bus.in_ready, 0);
        @(posedge clock);
        #1;
    endtask

    function automatic string gen_doc();
        string s = "";
        string txt = "hixyz ";
        string alph = "kqrs";
        byte   names[4];
        byte   st[$];
        byte   nm;
        names[0] = "d"; names[1] = "p"; names[2] = "b"; names[3] = "a";
        repeat ($urandom_range(6, 16)) begin
            int r = $urandom % 10;
            if (r < 4) s = $sformatf("%s%c", s, txt[$urandom % 6]);
            else if (r < 7) begin
                nm = names[$urandom % 4];
                if ($urandom % 3 == 0) begin
                    string at = "";
                    repeat ($urandom_range(1, 3)) at = $sformatf("%s%c", at, alph[$urandom % 4]);
                    s = $sformatf("%s<%c %s>", s, nm, at);
                end else s = $sformatf("%s<%c>", s, nm);
                st.push_back(nm);
            end else if (r < 9) begin
                if (st.size() > 0 && ($urandom % 6) != 0) nm = st.pop_back();
                else nm = names[$urandom % 4];
                s = $sformatf("%s</%c>", s, nm);
            end else s = $sformatf("%s\n", s);
        end
        while (st.size() > 0) s = $sformatf("%s</%c>", s, st.pop_back());
        return s;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        bus.in_valid = 0;
        bus.in_char  = '0;
        reset_dut();

        run_doc("<d>hi</d>", 0, 1);
        run_doc("<a href>x</a>", 0, 1);
        run_doc("<d><d><d><d><d><d><d><d><d>", 0, 1);
        run_doc("<d></p>", 0, 1);
        run_doc("</d>", 0, 1);
        run_doc("<d>abc</d>", 2, 1);

        // Asynchronous reset in the middle of a tag
        reset_dut();
        rdy_mode = 0;
        send_doc("<di");
        @(posedge clock);
        #3;
        check_val("pre_reset_p_enable", bus.p_enable, 1);
        reset_n = 0;
        #1;
        check_val("rst_in_ready", bus.in_ready, 0);
        check_val("rst_p_char", bus.p_char, 0);
        check_val("rst_p_enable", bus.p_enable, 0);
        check_val("rst_ev_valid", bus.ev_valid, 0);
        check_val("rst_ev_kind", bus.ev_kind, 0);
        check_val("rst_ev_tag", bus.ev_tag, 0);
        check_val("rst_ev_depth", bus.ev_depth, 0);
        check_val("rst_ev_attr_type", bus.ev_attr_type, 0);
        check_val("rst_ev_data", bus.ev_data, 0);
        check_val("rst_error", bus.error, 0);
        check_val("rst_error_code", bus.error_code, 0);
        @(posedge clock);
        #1;
        reset_n = 1;
        @(posedge clock);
        #1;
        run_doc("<p></p>", 0, 0);

        idle_max = 2;
        for (int t = 0; t < 25; t++) run_doc(gen_doc(), $urandom_range(0, 2), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
